// File: rtl/ldm_scan_ctrl.sv
// Row-scan scheduler for a 16x16 LED dot matrix: double-buffered frame capture
// with tear-free swaps and a LATCH/SHOW/BLANK row sequencer driving the panel pins.
module ldm_scan_ctrl #(
  parameter int unsigned DWELL = 8,
  parameter int unsigned BLANK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:255] PIXEL_DATA_256,
  input  logic         PIXEL_DATA_EN,
  output logic         LDM_CLK,
  output logic         LDM_ADDR_EN,
  output logic [3:0]   LDM_ADDR,
  output logic [0:15]  LDM_LINE_DATA,
  output logic         FRAME_PENDING,
  output logic         FRAME_START
);

  typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_SHOW, ST_BLANK} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);

  state_t       state, state_nxt;
  logic [3:0]   row, row_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic [0:255] shadow, active;
  logic         pending;
  logic         swap;
  logic         scanning;

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    cnt_nxt   = cnt;
    swap      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          swap      = 1'b1;
          state_nxt = ST_LATCH;
          row_nxt   = '0;
        end
      end
      ST_LATCH: begin
        state_nxt = ST_SHOW;
        cnt_nxt   = '0;
      end
      ST_SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_LATCH;
          row_nxt   = row + 4'd1;
          swap      = pending && (row == 4'd15);
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      row   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A strobe on the swap edge wins over the clear: active takes the old shadow,
  // the new frame stays pending for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (swap) active <= shadow;
      if (PIXEL_DATA_EN) begin
        shadow  <= PIXEL_DATA_256;
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    scanning      = (state != ST_IDLE);
    LDM_CLK       = (state == ST_LATCH);
    LDM_ADDR_EN   = (state == ST_SHOW);
    LDM_ADDR      = scanning ? row : '0;
    LDM_LINE_DATA = scanning ? active[{row, 4'b0000} +: 16] : '0;
    FRAME_PENDING = pending;
    FRAME_START   = LDM_CLK && (row == 4'd0);
  end

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
// Scoreboard bench for ldm_scan_ctrl: expected row latches are queued by the
// stimulus process and consumed by per-instance monitors on each LDM_CLK pulse.
module tb_ldm_scan_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:255] pix = '0;
  logic         en  = 1'b0;
  logic [0:255] pix2 = '0;
  logic         en2  = 1'b0;

  logic         ldm_clk, addr_en, pending, fstart;
  logic [3:0]   addr;
  logic [0:15]  line_data;
  logic         ldm_clk2, addr_en2, pending2, fstart2;
  logic [3:0]   addr2;
  logic [0:15]  line_data2;

  ldm_scan_ctrl dut (
    .clk(clk), .rst(rst), .PIXEL_DATA_256(pix), .PIXEL_DATA_EN(en),
    .LDM_CLK(ldm_clk), .LDM_ADDR_EN(addr_en), .LDM_ADDR(addr),
    .LDM_LINE_DATA(line_data), .FRAME_PENDING(pending), .FRAME_START(fstart)
  );

  ldm_scan_ctrl #(.DWELL(1), .BLANK(1)) dut_min (
    .clk(clk), .rst(rst), .PIXEL_DATA_256(pix2), .PIXEL_DATA_EN(en2),
    .LDM_CLK(ldm_clk2), .LDM_ADDR_EN(addr_en2), .LDM_ADDR(addr2),
    .LDM_LINE_DATA(line_data2), .FRAME_PENDING(pending2), .FRAME_START(fstart2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
    logic        fs;
    logic        p;
    int          per;   // cycles since previous latch, 0 = unchecked
    int          en;    // ADDR_EN cycles in previous row, -1 = unchecked
    int          fp;    // cycles since previous row-0 latch, 0 = unchecked
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad   = 0;

  logic [0:255] f1 = 256'hffff_7fff_3fff_1fff_0fff_07ff_03ff_01ff_00ff_007f_003f_001f_000f_0007_0003_0001;
  logic [0:255] fa, fb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int r, input logic [15:0] d, input logic p,
                              input int per, input int en_c, input int fp);
    exp_t e;
    e.a = 4'(r); e.d = d; e.fs = (r == 0); e.p = p;
    e.per = per; e.en = en_c; e.fp = fp;
    return e;
  endfunction

  function automatic logic [15:0] row_of(input logic [0:255] f, input int r);
    return f[16*r +: 16];
  endfunction

  // Monitor for the default-parameter instance
  int          cyc1 = 0, last1 = 0, f0_1 = 0, enc1 = 0;
  logic [3:0]  la1 = '0;
  logic [15:0] ld1 = '0;
  exp_t        e1;
  always @(negedge clk) begin
    if (rst) begin
      cyc1 = 0; last1 = 0; f0_1 = 0; enc1 = 0; la1 = '0; ld1 = '0;
    end else begin
      cyc1++;
      if (ldm_clk) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_latch actual=row%0d required=none t=%0t", addr, $time);
        end else begin
          e1 = q1.pop_front();
          chk("latch_addr", {28'b0, addr}, {28'b0, e1.a});
          chk("latch_data", {16'b0, line_data}, {16'b0, e1.d});
          chk("frame_start", {31'b0, fstart}, {31'b0, e1.fs});
          chk("latch_pending", {31'b0, pending}, {31'b0, e1.p});
          if (e1.per > 0) chk("row_period", cyc1 - last1, e1.per);
          if (e1.en >= 0) chk("addr_en_cycles", enc1, e1.en);
          if (e1.fp > 0) chk("frame_period", cyc1 - f0_1, e1.fp);
        end
        last1 = cyc1; enc1 = 0; la1 = addr; ld1 = line_data;
        if (addr == 4'd0) f0_1 = cyc1;
      end else begin
        if (addr_en) enc1++;
        chk("addr_hold", {28'b0, addr}, {28'b0, la1});
        chk("data_hold", {16'b0, line_data}, {16'b0, ld1});
        chk("fstart_low", {31'b0, fstart}, 32'd0);
      end
    end
  end

  // Monitor for the DWELL=1/BLANK=1 instance; retires once its queue drains
  int   cyc2 = 0, last2 = 0, f0_2 = 0, enc2 = 0;
  logic mon2_on = 1'b1;
  exp_t e2;
  always @(negedge clk) begin
    if (!rst && mon2_on) begin
      cyc2++;
      if (ldm_clk2) begin
        e2 = q2.pop_front();
        chk("min_addr", {28'b0, addr2}, {28'b0, e2.a});
        chk("min_data", {16'b0, line_data2}, {16'b0, e2.d});
        chk("min_fstart", {31'b0, fstart2}, {31'b0, e2.fs});
        if (e2.per > 0) chk("min_row_period", cyc2 - last2, e2.per);
        if (e2.en >= 0) chk("min_addr_en_cycles", enc2, e2.en);
        if (e2.fp > 0) chk("min_frame_period", cyc2 - f0_2, e2.fp);
        last2 = cyc2; enc2 = 0;
        if (addr2 == 4'd0) f0_2 = cyc2;
        if (q2.size() == 0) mon2_on = 1'b0;
      end else if (addr_en2) begin
        enc2++;
      end
    end
  end

  task automatic wait_latch(input logic [3:0] a, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ldm_clk && addr == a) && n < 400);
    if (!(ldm_clk && addr == a)) begin
      total++; bad++;
      $display("FAIL wait_%s actual=timeout required=latch_row%0d", tag, a);
    end
  endtask

  task automatic strobe(input logic [0:255] d);
    pix = d;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clk"}, {31'b0, ldm_clk}, 32'd0);
    chk({tag, "_addr_en"}, {31'b0, addr_en}, 32'd0);
    chk({tag, "_addr"}, {28'b0, addr}, 32'd0);
    chk({tag, "_data"}, {16'b0, line_data}, 32'd0);
    chk({tag, "_pending"}, {31'b0, pending}, 32'd0);
    chk({tag, "_fstart"}, {31'b0, fstart}, 32'd0);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      fa[16*r +: 16] = {4'hA, 4'(r), 8'h5A};
      fb[16*r +: 16] = {4'hB, 4'(r), 8'hC3};
    end

    // Frame 1: first F1 frame; frame 2: F1 again with zero frame pending from row 6
    for (int r = 0; r < 16; r++)
      q1.push_back(mk(r, row_of(f1, r), 1'b0, (r == 0) ? 0 : 11, (r == 0) ? -1 : 8, 0));
    for (int r = 0; r < 16; r++)
      q1.push_back(mk(r, row_of(f1, r), (r >= 6), 11, 8, (r == 0) ? 176 : 0));
    // Frame 3: zeros, frame A pending from row 4
    for (int r = 0; r < 16; r++)
      q1.push_back(mk(r, 16'h0000, (r >= 4), 11, 8, (r == 0) ? 176 : 0));
    // Frame 4: A shown while B stays pending; frame 5: B, reset lands in row 3
    for (int r = 0; r < 16; r++)
      q1.push_back(mk(r, row_of(fa, r), 1'b1, 11, 8, (r == 0) ? 176 : 0));
    for (int r = 0; r < 4; r++)
      q1.push_back(mk(r, row_of(fb, r), 1'b0, 11, 8, (r == 0) ? 176 : 0));

    for (int r = 0; r < 32; r++)
      q2.push_back(mk(r % 16, row_of(f1, r % 16), 1'b0, (r == 0) ? 0 : 3,
                      (r == 0) ? -1 : 1, (r == 16) ? 48 : 0));

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_all_zero("idle");

    pix2 = f1;
    en2  = 1'b1;
    strobe(f1);
    en2  = 1'b0;
    chk("first_pending", {31'b0, pending}, 32'd1);
    chk("first_no_latch_yet", {31'b0, ldm_clk}, 32'd0);
    chk("min_first_pending", {31'b0, pending2}, 32'd1);

    wait_latch(4'd0, "f1r0");
    wait_latch(4'd0, "f2r0");
    wait_latch(4'd5, "f2r5");
    repeat (2) @(negedge clk);
    strobe('0);
    chk("mid_pending", {31'b0, pending}, 32'd1);

    wait_latch(4'd0, "f3r0");
    wait_latch(4'd3, "f3r3");
    repeat (2) @(negedge clk);
    strobe(fa);
    chk("a_pending", {31'b0, pending}, 32'd1);

    // Strobe B so it is sampled on the edge that leaves row 15's last BLANK cycle
    wait_latch(4'd15, "f3r15");
    repeat (10) @(negedge clk);
    strobe(fb);
    chk("collide_pending", {31'b0, pending}, 32'd1);
    chk("collide_latch", {31'b0, ldm_clk}, 32'd1);

    wait_latch(4'd0, "f5r0");
    wait_latch(4'd3, "f5r3");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      chk("post_rst_clk", {31'b0, ldm_clk}, 32'd0);
      chk("post_rst_pending", {31'b0, pending}, 32'd0);
      chk("post_rst_addr_en", {31'b0, addr_en}, 32'd0);
    end

    q1.push_back(mk(0, row_of(f1, 0), 1'b0, 0, -1, 0));
    strobe(f1);
    wait_latch(4'd0, "rst_r0");
    repeat (3) @(negedge clk);

    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
